slave_mem: RTL and testbench
============================

// Module: slave_mem
// PURPOSE
// - Word-addressed RAM slave that sits downstream of the 2x2 crossbar; one instance per crossbar slave port.
// - Completes one read or write per request, then returns an ack pulse after a programmable latency.
// - Drives rdata=0 except in the ack cycle, so the crossbar may OR-combine read data safely.
// PARAMETERS
// - ADDR_W   8  number of word-address bits; memory depth is 2**ADDR_W words of 32 bits
// - LATENCY  2  cycles from req accepted (IDLE->WAIT edge) to the ack cycle; legal range 1..15
// PORTS
// - clk    in   1   clock; all state changes on the rising edge
// - rst    in   1   synchronous, active-high reset
// - req    in   1   request valid; held high, with cmd/addr/wdata stable, until ack
// - cmd    in   1   0=read, 1=write
// - addr   in   32  byte address; addr[31] is the crossbar slave select (ignored here); word index = addr[ADDR_W+1:2]
// - wdata  in   32  write data
// - rdata  out  32  read data; valid only when ack=1 and the latched cmd is 0, otherwise 32'h0
// - ack    out  1   one-cycle completion pulse
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE, ack=0, rdata=0, wait counter=0, latched cmd/addr/wdata=0.
//   RAM contents are not reset. Reset mid-transaction drops the request: no ack, no RAM write.
// - FSM states:
//   - IDLE: if req=1, latch cmd, word index and wdata; load cnt=LATENCY-1; go to WAIT (or ACK if LATENCY=1).
//   - WAIT: cnt decrements each cycle; at cnt==0 go to ACK. Changes on req/cmd/addr are ignored (latched copy used).
//   - ACK:  ack=1 for exactly this cycle. Write: RAM[idx]<=wdata on the edge leaving ACK.
//           Read: rdata=RAM[idx]. Always go to IDLE next.
// - Latency: req first seen high at edge N -> ack high during cycle N+LATENCY.
// - No back-to-back acks: after an ack, at least one IDLE cycle always precedes the next accept.
//   Minimum request-to-request period = LATENCY+1.
// - A requester that keeps req high after ack is treated as a new request in the following IDLE cycle (by design).
// - Write-then-read to the same word: the read returns the new data (the write commits before IDLE).
// - ack and rdata are registered outputs, with no combinational path from any input.
// - Index width: addr bits above ADDR_W+1 (except the ignored addr[31]) are dropped. Addresses wrap modulo the depth.
// - addr[1:0] are ignored, so unaligned addresses access the containing word.
// CONFIGURATION
// - SLAVE_MEM_JITTER_EN defined:
//   - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on rst) advances every cycle.
//   - On accept, cnt=LATENCY-1+lfsr[1:0], adding 0..3 extra wait cycles to stress arbitration.
//   - A zero total wait still goes straight to ACK.
// - SLAVE_MEM_JITTER_EN undefined: latency is exactly LATENCY and no LFSR logic is built.
// TESTING
// - Reset: assert rst 2 cycles while req=1 -> ack=0, rdata=0 throughout; no RAM write occurs.
// - Write/read, LATENCY=2: write addr=32'h0000_0010, wdata=32'hDEAD_BEEF at edge 0 -> ack in cycle 2.
//   Then read same addr -> ack 2 cycles after accept, rdata=32'hDEAD_BEEF; rdata=0 in all other cycles.
// - Held req: keep req=1 with cmd=1 across 3 transactions -> acks in cycles 2, 5 and 8, never adjacent.
// - Input change during WAIT: change addr to 32'h0000_0020 and wdata to 0 one cycle after accept.
//   -> the original addr 32'h10 is written with the original data; word 0x20 is unchanged.
// - Wrap, ADDR_W=8: write 32'h1234_5678 to addr 32'h8000_0400 -> a read of addr 32'h0000_0000 returns 32'h1234_5678.
// - Mid-op reset: rst=1 in the WAIT cycle of a write to 32'h10 -> no ack, and a later read of 32'h10 returns the old value.
//   With SLAVE_MEM_JITTER_EN, 100 reads show ack latency in 2..5 and never an ack without a req.

Source files
------------

// File: rtl/slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : slave_mem
// Purpose  : Word-addressed 32-bit RAM slave behind the 2x2 crossbar. It
//            accepts one read or write per request and returns a one-cycle
//            ack after a programmable latency. o_rdata is forced to zero
//            outside the ack cycle so that slave outputs can be OR-combined.
// Ports    : clk      - clock, rising edge
//            rst      - synchronous active-high reset
//            i_req    - request valid, held with cmd/addr/wdata until ack
//            i_cmd    - 0 = read, 1 = write
//            i_addr   - byte address; word index = i_addr[ADDR_W+1:2]
//            i_wdata  - write data
//            o_rdata  - read data, non-zero only in the ack cycle of a read
//            o_ack    - one-cycle completion pulse
// Params   : ADDR_W (word-address bits), LATENCY (1..15)
// Options  : SLAVE_MEM_JITTER_EN adds 0..3 pseudo-random wait cycles per
//            request from an 8-bit LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module slave_mem #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic        i_cmd,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ack
);

   localparam int         c_DEPTH  = 2 ** ADDR_W;
   localparam logic [4:0] c_LAT_M1 = 5'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t              r_state;
   logic [4:0]          r_cnt;      // WAIT cycles still to spend
   logic                r_cmd;
   logic [ADDR_W-1:0]   r_idx;
   logic [31:0]         r_wdata;
   logic [31:0]         r_mem [0:c_DEPTH-1];

   logic [ADDR_W-1:0]   w_in_idx;
   logic [4:0]          w_load;
   logic                w_mem_we;
   logic                w_unused;

   // Byte lanes and bits above the index (including the crossbar select
   // bit 31) do not take part in addressing; addresses wrap on the depth.
   assign w_in_idx = i_addr[ADDR_W+1:2];
   assign w_unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0]};

`ifdef SLAVE_MEM_JITTER_EN
   logic [7:0] r_lfsr;

   // Fibonacci LFSR for x^8 + x^6 + x^5 + x^4 + 1, free-running.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= 8'hA5;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign w_load = c_LAT_M1 + {3'b000, r_lfsr[1:0]};
`else
   assign w_load = c_LAT_M1;
`endif

   // The write commits on the edge leaving ACK, so a following read (which
   // can only be accepted from IDLE afterwards) sees the new data. A reset
   // on that same edge drops the write.
   assign w_mem_we = (r_state == S_ACK) && r_cmd && !rst;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 5'd0;
         r_cmd   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= 32'h0;
         o_ack   <= 1'b0;
         o_rdata <= 32'h0;
      end else begin
         o_ack   <= 1'b0;
         o_rdata <= 32'h0;
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_cmd   <= i_cmd;
                  r_idx   <= w_in_idx;
                  r_wdata <= i_wdata;
                  r_cnt   <= w_load;
                  if (w_load == 5'd0) begin
                     // Zero wait: the ack cycle follows the accept directly.
                     r_state <= S_ACK;
                     o_ack   <= 1'b1;
                     o_rdata <= i_cmd ? 32'h0 : r_mem[w_in_idx];
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Leaving WAIT when the decrement would reach zero gives
               // exactly w_load WAIT cycles.
               if (r_cnt == 5'd1) begin
                  r_cnt   <= 5'd0;
                  r_state <= S_ACK;
                  o_ack   <= 1'b1;
                  o_rdata <= r_cmd ? 32'h0 : r_mem[r_idx];
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            S_ACK: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_mem
// Purpose  : Self-checking bench for slave_mem (ADDR_W=8, LATENCY=2).
//            Directed transactions push their expected read data to a queue;
//            a negedge monitor pops it on every ack and also requires
//            o_rdata=0 in every non-ack cycle and no adjacent acks.
// Options  : honours SLAVE_MEM_JITTER_EN (latency window instead of exact).
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_mem;

   localparam int c_ADDR_W  = 8;
   localparam int c_LATENCY = 2;
   // Negedges counted from raising i_req (just after an edge) to the first
   // negedge where ack is seen: one edge to accept plus LATENCY.
   localparam int c_LAT_NE  = c_LATENCY + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic        i_cmd;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_ack;

   int          n_total = 0;
   int          n_pass  = 0;
   int          cyc     = 0;
   bit          mon_en  = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] exp_q[$];
   int          ack_cyc_q[$];

   slave_mem #(
      .ADDR_W  (c_ADDR_W),
      .LATENCY (c_LATENCY)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_cmd   (i_cmd),
      .i_addr  (i_addr),
      .i_wdata (i_wdata),
      .o_rdata (o_rdata),
      .o_ack   (o_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_ack) begin
            ack_cyc_q.push_back(cyc);
            chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("ack_rdata", o_rdata, exp_q.pop_front());
            chk("ack_not_adjacent", 32'(prev_ack), 32'd0);
         end else begin
            chk("idle_rdata_zero", o_rdata, 32'h0);
         end
         prev_ack = o_ack;
      end
   end

   task automatic txn(input string tag, input logic c, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd);
      int  n;
      bit  seen;
      @(posedge clk); #1;
      i_req   = 1'b1;
      i_cmd   = c;
      i_addr  = a;
      i_wdata = d;
      exp_q.push_back(c ? 32'h0 : exp_rd);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (o_ack) seen = 1'b1;
      end
      i_req = 1'b0;
      chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
`ifdef SLAVE_MEM_JITTER_EN
      chk({tag, "_latency_window"}, 32'(n >= c_LAT_NE && n <= c_LAT_NE + 3), 32'd1);
`else
      chk({tag, "_latency"}, 32'(n), 32'(c_LAT_NE));
`endif
   endtask

   initial begin
      int n;
      // Reset held 2 cycles with a live write request: nothing may happen.
      rst = 1'b1; i_req = 1'b1; i_cmd = 1'b1;
      i_addr = 32'h0000_0010; i_wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; i_req = 1'b0;
      chk("reset_ack", 32'(o_ack), 32'd0);
      chk("reset_rdata", o_rdata, 32'h0);

      txn("wr10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
      txn("rd10", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
      txn("wr20", 1'b1, 32'h0000_0020, 32'h5555_AAAA, 32'h0);

      // Held request: three back-to-back writes without dropping i_req.
      @(posedge clk); #1;
      ack_cyc_q.delete();
      repeat (3) exp_q.push_back(32'h0);
      i_req = 1'b1; i_cmd = 1'b1; i_addr = 32'h0000_0040; i_wdata = 32'h1111_2222;
      n = 0;
      while (ack_cyc_q.size() < 3 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      i_req = 1'b0;
      chk("held_ack_count", 32'(ack_cyc_q.size()), 32'd3);
      if (ack_cyc_q.size() >= 3) begin
`ifdef SLAVE_MEM_JITTER_EN
         chk("held_gap1", 32'(ack_cyc_q[1] - ack_cyc_q[0] >= c_LATENCY + 1), 32'd1);
         chk("held_gap2", 32'(ack_cyc_q[2] - ack_cyc_q[1] >= c_LATENCY + 1), 32'd1);
`else
         chk("held_gap1", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'(c_LATENCY + 1));
         chk("held_gap2", 32'(ack_cyc_q[2] - ack_cyc_q[1]), 32'(c_LATENCY + 1));
`endif
      end
      repeat (3) @(posedge clk);
      chk("held_no_extra", 32'(exp_q.size()), 32'd0);
      txn("rd40", 1'b0, 32'h0000_0040, 32'h0, 32'h1111_2222);

      // Inputs change after accept: the latched copy must be used.
      @(posedge clk); #1;
      exp_q.push_back(32'h0);
      i_req = 1'b1; i_cmd = 1'b1; i_addr = 32'h0000_0010; i_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      i_addr = 32'h0000_0020; i_wdata = 32'h0;
      n = 0;
      while (!o_ack && n < 40) begin
         @(negedge clk);
         n++;
      end
      i_req = 1'b0;
      chk("chg_ack_seen", 32'(o_ack), 32'd1);
      txn("chg_rd10", 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D);
      txn("chg_rd20", 1'b0, 32'h0000_0020, 32'h0, 32'h5555_AAAA);

      // Wrap modulo depth, unaligned access, ignored select bit.
      txn("wrap_wr", 1'b1, 32'h8000_0400, 32'h1234_5678, 32'h0);
      txn("wrap_rd0", 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678);
      txn("unalign_rd", 1'b0, 32'h0000_0003, 32'h0, 32'h1234_5678);
      txn("sel_rd", 1'b0, 32'h8000_0010, 32'h0, 32'hCAFE_F00D);

      // Reset during WAIT of a write: no ack, no RAM update.
      @(posedge clk); #1;
      i_req = 1'b1; i_cmd = 1'b1; i_addr = 32'h0000_0010; i_wdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      rst = 1'b1; i_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_ack", 32'(o_ack), 32'd0);
      repeat (3) @(posedge clk);
      chk("midrst_no_pending", 32'(exp_q.size()), 32'd0);
      txn("midrst_rd10", 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D);

`ifdef SLAVE_MEM_JITTER_EN
      for (int i = 0; i < 100; i++) begin
         txn("jit_rd", 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678);
      end
`else
      txn("rd_w40", 1'b0, 32'h0000_0041, 32'h0, 32'h1111_2222);
      txn("rd_w20", 1'b0, 32'h0000_0022, 32'h0, 32'h5555_AAAA);
`endif

      repeat (4) @(posedge clk);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
